upower_fetch_decode: RTL and testbench

Instruction fetch and DS-format decode stage of the uPOWER datapath. Holds the program counter and a small loadable instruction memory, fetches one 32-bit word per accepted transfer, and splits it into the PO/RT/RA/DS/XO fields and a sign-extended displacement consumed by the downstream load/store execute stage. Output is a registered valid/ready channel with stall, branch-redirect flush and an optional illegal-opcode halt.

---
 rtl/upower_pkg.sv | 30 +++
 rtl/upower_ds_field_decode.sv | 39 +++
 rtl/upower_fetch_decode.sv | 135 +++++++++++++
 tb/tb_upower_fetch_decode.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/upower_pkg.sv
// Shared uPOWER definitions: DS-form opcode/extended-opcode constants,
// instruction field positions, address width and the fetch-stage states.
package upower_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned INSTR_W = 32;

  localparam logic [5:0] PO_LD  = 6'd58;
  localparam logic [5:0] PO_STD = 6'd62;

  localparam logic [1:0] XO_BASE   = 2'd0;
  localparam logic [1:0] XO_UPDATE = 2'd1;

  localparam int unsigned PO_MSB = 31;
  localparam int unsigned PO_LSB = 26;
  localparam int unsigned RT_MSB = 25;
  localparam int unsigned RT_LSB = 21;
  localparam int unsigned RA_MSB = 20;
  localparam int unsigned RA_LSB = 16;
  localparam int unsigned DS_MSB = 15;
  localparam int unsigned DS_LSB = 2;
  localparam int unsigned XO_MSB = 1;
  localparam int unsigned XO_LSB = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fd_state_t;

endpackage

// File: rtl/upower_ds_field_decode.sv
// Combinational DS-form decoder: splits an instruction word into its fields,
// sign-extends the word-aligned displacement and classifies ld/ldu/std/stdu.
module upower_ds_field_decode
  import upower_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [5:0]         po,
  output logic [4:0]         rt,
  output logic [4:0]         ra,
  output logic [13:0]        ds,
  output logic [1:0]         xo,
  output logic [ADDR_W-1:0]  disp,
  output logic               is_ld,
  output logic               is_std,
  output logic               is_update,
  output logic               illegal
);

  assign po   = instr[PO_MSB:PO_LSB];
  assign rt   = instr[RT_MSB:RT_LSB];
  assign ra   = instr[RA_MSB:RA_LSB];
  assign ds   = instr[DS_MSB:DS_LSB];
  assign xo   = instr[XO_MSB:XO_LSB];
  assign disp = {{(ADDR_W - 16){ds[13]}}, ds, 2'b00};

  always_comb begin
    is_ld     = 1'b0;
    is_std    = 1'b0;
    is_update = 1'b0;
    illegal   = 1'b1;
    if ((po == PO_LD || po == PO_STD) && (xo == XO_BASE || xo == XO_UPDATE)) begin
      is_ld     = (po == PO_LD);
      is_std    = (po == PO_STD);
      is_update = (xo == XO_UPDATE);
      illegal   = 1'b0;
    end
  end

endmodule

// File: rtl/upower_fetch_decode.sv
// uPOWER fetch/DS-decode stage: PC, loadable instruction memory and a registered
// valid/ready output. Define UPOWER_FD_ILLEGAL_TRAP_EN to halt on illegal opcodes.
module upower_fetch_decode
  import upower_pkg::*;
#(
  parameter int unsigned       IMEM_DEPTH = 64,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [INSTR_W-1:0]            imem_wdata,
  input  logic                          redirect_valid,
  input  logic [ADDR_W-1:0]             redirect_pc,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [ADDR_W-1:0]             out_pc,
  output logic [INSTR_W-1:0]            out_instr,
  output logic [5:0]                    po,
  output logic [4:0]                    rt,
  output logic [4:0]                    ra,
  output logic [13:0]                   ds,
  output logic [1:0]                    xo,
  output logic [ADDR_W-1:0]             disp,
  output logic                          is_ld,
  output logic                          is_std,
  output logic                          is_update,
  output logic                          illegal,
  output logic                          halted
);

  localparam int unsigned IDX_W = $clog2(IMEM_DEPTH);

  logic [INSTR_W-1:0] imem [IMEM_DEPTH];
  logic [ADDR_W-1:0]  fpc;
  logic [INSTR_W-1:0] fetch_word;
  fd_state_t          state, state_next;
  logic               load;

  logic [5:0]        d_po;
  logic [4:0]        d_rt, d_ra;
  logic [13:0]       d_ds;
  logic [1:0]        d_xo;
  logic [ADDR_W-1:0] d_disp;
  logic              d_is_ld, d_is_std, d_is_update, d_illegal;

  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  assign fetch_word = imem[fpc[IDX_W+1:2]];

  upower_ds_field_decode u_decode (
    .instr     (fetch_word),
    .po        (d_po),
    .rt        (d_rt),
    .ra        (d_ra),
    .ds        (d_ds),
    .xo        (d_xo),
    .disp      (d_disp),
    .is_ld     (d_is_ld),
    .is_std    (d_is_std),
    .is_update (d_is_update),
    .illegal   (d_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      ST_RUN: begin
        load = !out_valid || out_ready;
`ifdef UPOWER_FD_ILLEGAL_TRAP_EN
        if (load && d_illegal) state_next = ST_HALT;
`endif
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_RUN;
    endcase
    if (redirect_valid) state_next = ST_RUN;
  end

  // Redirect outranks load; in HALT the last word is only retired, never replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc       <= RESET_PC;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
      po        <= '0;
      rt        <= '0;
      ra        <= '0;
      ds        <= '0;
      xo        <= '0;
      disp      <= '0;
      is_ld     <= 1'b0;
      is_std    <= 1'b0;
      is_update <= 1'b0;
      illegal   <= 1'b0;
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
      fpc       <= redirect_pc & ~64'd3;
    end else if (load) begin
      fpc       <= fpc + 64'd4;
      out_valid <= 1'b1;
      out_pc    <= fpc;
      out_instr <= fetch_word;
      po        <= d_po;
      rt        <= d_rt;
      ra        <= d_ra;
      ds        <= d_ds;
      xo        <= d_xo;
      disp      <= d_disp;
      is_ld     <= d_is_ld;
      is_std    <= d_is_std;
      is_update <= d_is_update;
      illegal   <= d_illegal;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef UPOWER_FD_ILLEGAL_TRAP_EN
  assign halted = (state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_upower_fetch_decode.sv
// Directed self-checking bench for upower_fetch_decode (IMEM_DEPTH=64, RESET_PC=0).
module tb_upower_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [5:0]  po;
  logic [4:0]  rt, ra;
  logic [13:0] ds;
  logic [1:0]  xo;
  logic [63:0] disp;
  logic        is_ld, is_std, is_update, illegal, halted;

  int passed = 0;
  int total  = 0;

  upower_fetch_decode #(.IMEM_DEPTH(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .po(po), .rt(rt), .ra(ra), .ds(ds), .xo(xo), .disp(disp), .is_ld(is_ld),
    .is_std(is_std), .is_update(is_update), .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [5:0] idx, input logic [31:0] data);
    imem_we = 1'b1; imem_waddr = idx; imem_wdata = data;
    step();
    imem_we = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", out_valid); else passed++;
    total++; if (out_pc !== 64'h0) $display("FAIL rst_pc got %h exp 0", out_pc); else passed++;
    total++; if (out_instr !== 32'h0) $display("FAIL rst_instr got %h exp 0", out_instr); else passed++;
    total++; if ({is_ld, is_std, is_update, illegal, halted} !== 5'b0)
      $display("FAIL rst_flags got %b exp 00000", {is_ld, is_std, is_update, illegal, halted}); else passed++;
    rst_n = 1'b1;
    step();
    total++; if (out_valid !== 1'b1) $display("FAIL ld_valid got %b exp 1", out_valid); else passed++;
    total++; if (out_pc !== 64'h0) $display("FAIL ld_pc got %h exp 0", out_pc); else passed++;
    total++; if (rt !== 5'd3 || ra !== 5'd4) $display("FAIL ld_regs got rt=%0d ra=%0d exp 3 4", rt, ra); else passed++;
    total++; if (disp !== 64'd8) $display("FAIL ld_disp got %h exp 8", disp); else passed++;
    total++; if ({is_ld, is_std, is_update, illegal} !== 4'b1000)
      $display("FAIL ld_flags got %b exp 1000", {is_ld, is_std, is_update, illegal}); else passed++;
  endtask

  task automatic test_std();
    step();
    total++; if (out_pc !== 64'h4) $display("FAIL std_pc got %h exp 4", out_pc); else passed++;
    total++; if (po !== 6'd62 || rt !== 5'd3 || ra !== 5'd5)
      $display("FAIL std_fields got po=%0d rt=%0d ra=%0d exp 62 3 5", po, rt, ra); else passed++;
    total++; if (disp !== 64'hFFFF_FFFF_FFFF_FFF8) $display("FAIL std_disp got %h exp fffffffffffffff8", disp); else passed++;
    total++; if ({is_ld, is_std, is_update, illegal} !== 4'b0100)
      $display("FAIL std_flags got %b exp 0100", {is_ld, is_std, is_update, illegal}); else passed++;
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_valid !== 1'b1 || out_pc !== 64'h4 || out_instr !== 32'hF865FFF8 || disp !== 64'hFFFF_FFFF_FFFF_FFF8)
        $display("FAIL stall_hold[%0d] got v=%b pc=%h instr=%h disp=%h exp 1 4 f865fff8 fffffffffffffff8",
                 i, out_valid, out_pc, out_instr, disp); else passed++;
    end
    out_ready = 1'b1;
    step();
    total++; if (out_pc !== 64'h8 || out_instr !== 32'h7C000000)
      $display("FAIL stall_next got pc=%h instr=%h exp 8 7c000000", out_pc, out_instr); else passed++;
    total++; if (po !== 6'd31 || {is_ld, is_std, is_update, illegal} !== 4'b0001)
      $display("FAIL illegal_flags got po=%0d flags=%b exp 31 0001", po, {is_ld, is_std, is_update, illegal}); else passed++;
  endtask

  task automatic test_illegal();
    step();
`ifdef UPOWER_FD_ILLEGAL_TRAP_EN
    total++; if (out_valid !== 1'b0 || halted !== 1'b1)
      $display("FAIL halt_enter got v=%b halted=%b exp 0 1", out_valid, halted); else passed++;
    out_ready = 1'b0;
    step();
    total++; if (out_valid !== 1'b0 || halted !== 1'b1 || out_pc !== 64'h8)
      $display("FAIL halt_stay got v=%b halted=%b pc=%h exp 0 1 8", out_valid, halted, out_pc); else passed++;
`else
    total++; if (out_valid !== 1'b1 || out_pc !== 64'hC || halted !== 1'b0)
      $display("FAIL illegal_flow got v=%b pc=%h halted=%b exp 1 c 0", out_valid, out_pc, halted); else passed++;
    total++; if ({is_ld, is_std, is_update, illegal} !== 4'b1010)
      $display("FAIL ldu_flags got %b exp 1010", {is_ld, is_std, is_update, illegal}); else passed++;
    out_ready = 1'b0;
    step();
    total++; if (out_valid !== 1'b1 || out_pc !== 64'hC)
      $display("FAIL ldu_hold got v=%b pc=%h exp 1 c", out_valid, out_pc); else passed++;
`endif
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 64'h13;
    step();
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || halted !== 1'b0)
      $display("FAIL redir_bubble got v=%b halted=%b exp 0 0", out_valid, halted); else passed++;
    step();
    total++; if (out_valid !== 1'b1 || out_pc !== 64'h10 || out_instr !== 32'hF865FFF9)
      $display("FAIL redir_target got v=%b pc=%h instr=%h exp 1 10 f865fff9", out_valid, out_pc, out_instr); else passed++;
    total++; if ({is_ld, is_std, is_update, illegal} !== 4'b0110)
      $display("FAIL stdu_flags got %b exp 0110", {is_ld, is_std, is_update, illegal}); else passed++;
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 64'hFC;
    step();
    redirect_valid = 1'b0;
    step();
    total++; if (out_pc !== 64'hFC || out_instr !== 32'hE8A6FFFC || disp !== 64'hFFFF_FFFF_FFFF_FFFC)
      $display("FAIL wrap_63 got pc=%h instr=%h disp=%h exp fc e8a6fffc fffffffffffffffc", out_pc, out_instr, disp); else passed++;
    total++; if (rt !== 5'd5 || ra !== 5'd6) $display("FAIL wrap_regs got rt=%0d ra=%0d exp 5 6", rt, ra); else passed++;
    step();
    total++; if (out_pc !== 64'h100 || out_instr !== 32'hE8640008)
      $display("FAIL wrap_0 got pc=%h instr=%h exp 100 e8640008", out_pc, out_instr); else passed++;
  endtask

  task automatic test_write_collision();
    write_word(6'd1, 32'hF8A00005);
    total++; if (out_pc !== 64'h104 || out_instr !== 32'hF865FFF8)
      $display("FAIL wr_old got pc=%h instr=%h exp 104 f865fff8", out_pc, out_instr); else passed++;
    redirect_valid = 1'b1; redirect_pc = 64'h4;
    step();
    redirect_valid = 1'b0;
    step();
    total++; if (out_pc !== 64'h4 || out_instr !== 32'hF8A00005 || disp !== 64'h4 || ra !== 5'd0)
      $display("FAIL wr_new got pc=%h instr=%h disp=%h ra=%0d exp 4 f8a00005 4 0", out_pc, out_instr, disp, ra); else passed++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h40;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_pc !== 64'h0 || out_instr !== 32'h0 || disp !== 64'h0)
      $display("FAIL arst got v=%b pc=%h instr=%h disp=%h exp 0 0 0 0", out_valid, out_pc, out_instr, disp); else passed++;
    redirect_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== 32'hE8640008)
      $display("FAIL arst_restart got v=%b pc=%h instr=%h exp 1 0 e8640008", out_valid, out_pc, out_instr); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    write_word(6'd0,  32'hE8640008);
    write_word(6'd1,  32'hF865FFF8);
    write_word(6'd2,  32'h7C000000);
    write_word(6'd3,  32'hE8640009);
    write_word(6'd4,  32'hF865FFF9);
    write_word(6'd63, 32'hE8A6FFFC);
    test_reset();
    test_std();
    test_stall();
    test_illegal();
    test_redirect();
    test_wrap();
    test_write_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
